// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the combinational instruction ROM at pc,
// buffers fetched words (or fault markers) in a small FIFO and presents
// the FIFO head to decode over a valid/ready handshake. Downstream
// redirects flush the buffer and restart fetch at a new address.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_SIZE   = 4 << 20,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Highest byte address at which a full 32-bit word still fits in the ROM.
  localparam logic [31:0] ROM_LAST = 32'(ROM_SIZE - 4);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] entry_pc_q    [FIFO_DEPTH];
  logic [31:0] entry_instr_q [FIFO_DEPTH];
  logic        entry_fault_q [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic        pc_fault;
  logic [31:0] push_instr;

  assign rom_addr  = pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = entry_pc_q[head_q];
  assign out_instr = entry_instr_q[head_q];
  assign out_fault = entry_fault_q[head_q];

  // Next-state logic: redirect beats everything, otherwise push when room and pop on handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pop        = out_valid && out_ready;
    pc_fault   = (pc_q[1:0] != 2'b00) || (pc_q > ROM_LAST);
    push       = !redirect_valid && (state_q == FETCH) && (count_q < DEPTH_C);
    push_instr = pc_fault ? 32'h0 : rom_data;

    if (redirect_valid) begin
      state_d = FETCH;
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        if (pc_fault) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: fetch state, pc and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: cleared on reset so an empty FIFO presents zeros on out_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entry_pc_q[i]    <= 32'h0;
        entry_instr_q[i] <= 32'h0;
        entry_fault_q[i] <= 1'b0;
      end
    end else if (push) begin
      entry_pc_q[tail_q]    <= pc_q;
      entry_instr_q[tail_q] <= push_instr;
      entry_fault_q[tail_q] <= pc_fault;
    end
  end

endmodule
